// File: rtl/spi_slave_responder_pkg.sv
// spi_slave_responder_pkg: shared SPI globals (edge, direction, mode and state enums, default character length)
package spi_slave_responder_pkg;
  localparam int CHAR_LENGTH = 8;
  typedef enum logic [1:0] {NO_EDGE, POSEDGE, NEGEDGE} edgeDetectEnum;
  typedef enum logic {LSB_FIRST, MSB_FIRST} shiftDirectionEnum;
  typedef enum logic [1:0] {MODE0, MODE1, MODE2, MODE3} operationModesEnum;
  typedef enum logic {IDLE, ACTIVE} stateEnum;
endpackage

// File: rtl/spi_sync_edge_detect.sv
// spi_sync_edge_detect: multi-flop synchronizer with posedge/negedge classification of the synchronized level
module spi_sync_edge_detect
  import spi_slave_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          pclk,
  input  logic          areset,
  input  logic          din,
  output logic          dout,
  output edgeDetectEnum edge_type
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end
  always_ff @(posedge pclk) begin
    if (areset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign dout = sync_q[SYNC_STAGES-1];
  assign edge_type = (dout && !prev_q) ? POSEDGE : (!dout && prev_q) ? NEGEDGE : NO_EDGE;
endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder: SPI slave with one-deep TX holding register; SPI_SLAVE_CHAR_COUNT_EN adds the charCount output
module spi_slave_responder #(
  parameter int CHAR_LENGTH = spi_slave_responder_pkg::CHAR_LENGTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   msbFirst,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi0,
  output logic                   miso0,
  output logic                   misoOe,
  input  logic [CHAR_LENGTH-1:0] txData,
  input  logic                   txValid,
  output logic                   txReady,
  output logic [CHAR_LENGTH-1:0] rxData,
  output logic                   rxValid,
  output logic                   txUnderrun,
  output logic                   busy
`ifdef SPI_SLAVE_CHAR_COUNT_EN
  ,
  output logic [15:0]            charCount
`endif
);
  import spi_slave_responder_pkg::*;
  localparam int CW = $clog2(CHAR_LENGTH);
  function automatic logic first_bit(input logic [CHAR_LENGTH-1:0] v, input logic m);
    return m ? v[CHAR_LENGTH-1] : v[0];
  endfunction
  edgeDetectEnum sclk_edge, cs_edge, mosi_edge_unused;
  logic sclk_level_unused, cs_level_unused, mosi_s;
  spi_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .pclk(pclk), .areset(areset), .din(sclk), .dout(sclk_level_unused), .edge_type(sclk_edge)
  );
  spi_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .pclk(pclk), .areset(areset), .din(cs), .dout(cs_level_unused), .edge_type(cs_edge)
  );
  spi_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .pclk(pclk), .areset(areset), .din(mosi0), .dout(mosi_s), .edge_type(mosi_edge_unused)
  );
  stateEnum state_q, state_d;
  operationModesEnum mode_q, mode_d;
  shiftDirectionEnum dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CHAR_LENGTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic hold_valid_q, hold_valid_d, fresh_q, fresh_d, miso_q, miso_d, oe_q, oe_d;
  logic rx_valid_q, rx_valid_d, under_q, under_d;
  logic cs_fall, cs_rise, start, lead, trail, sample, shift, last, load, msb;
  logic [CHAR_LENGTH-1:0] load_val, rx_next, tx_next;
  always_comb begin
    cs_fall = cs_edge == NEGEDGE;
    cs_rise = cs_edge == POSEDGE;
    start = state_q == IDLE && cs_fall;
    lead = mode_q[1] ? sclk_edge == NEGEDGE : sclk_edge == POSEDGE;
    trail = mode_q[1] ? sclk_edge == POSEDGE : sclk_edge == NEGEDGE;
    sample = state_q == ACTIVE && !cs_rise && (mode_q[0] ? trail : lead);
    shift = state_q == ACTIVE && !cs_rise && (mode_q[0] ? lead : trail);
    msb = state_q == IDLE ? msbFirst : dir_q == MSB_FIRST;
    last = cnt_q == CW'(CHAR_LENGTH - 1);
    load = start || (sample && last);
    load_val = hold_valid_q ? hold_q : '1;
    rx_next = msb ? {rx_sh_q[CHAR_LENGTH-2:0], mosi_s} : {mosi_s, rx_sh_q[CHAR_LENGTH-1:1]};
    tx_next = msb ? {tx_sh_q[CHAR_LENGTH-2:0], 1'b0} : {1'b0, tx_sh_q[CHAR_LENGTH-1:1]};
    state_d = cs_rise ? IDLE : cs_fall ? ACTIVE : state_q;
    mode_d = start ? operationModesEnum'({cpol, cpha}) : mode_q;
    dir_d = start ? shiftDirectionEnum'(msbFirst) : dir_q;
    cnt_d = (cs_rise || state_q == IDLE) ? '0 : sample ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    rx_sh_d = sample ? rx_next : rx_sh_q;
    rx_data_d = (sample && last) ? rx_next : rx_data_q;
    rx_valid_d = sample && last;
    under_d = load && !hold_valid_q;
    tx_sh_d = load ? load_val : (shift && !fresh_q) ? tx_next : tx_sh_q;
    // A freshly loaded character presents its first bit on the next shift edge without shifting
    fresh_d = load ? !(start && !cpha) : shift ? 1'b0 : fresh_q;
    miso_d = state_d == IDLE ? 1'b0
           : (start && !cpha) ? first_bit(load_val, msb)
           : shift ? (fresh_q ? first_bit(tx_sh_q, msb) : first_bit(tx_next, msb))
           : miso_q;
    oe_d = state_d == ACTIVE;
    hold_d = (txValid && !hold_valid_q) ? txData : hold_q;
    hold_valid_d = (hold_valid_q && !load) || (txValid && !hold_valid_q);
  end
  always_ff @(posedge pclk) begin
    if (areset) begin
      state_q <= IDLE;
      mode_q <= MODE0;
      dir_q <= LSB_FIRST;
      cnt_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      hold_q <= '0;
      rx_data_q <= '0;
      hold_valid_q <= 1'b0;
      fresh_q <= 1'b0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      rx_valid_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      hold_q <= hold_d;
      rx_data_q <= rx_data_d;
      hold_valid_q <= hold_valid_d;
      fresh_q <= fresh_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      rx_valid_q <= rx_valid_d;
      under_q <= under_d;
    end
  end
  assign miso0 = miso_q;
  assign misoOe = oe_q;
  assign txReady = !hold_valid_q;
  assign rxData = rx_data_q;
  assign rxValid = rx_valid_q;
  assign txUnderrun = under_q;
  assign busy = state_q == ACTIVE;
`ifdef SPI_SLAVE_CHAR_COUNT_EN
  logic [15:0] char_count_q, char_count_d;
  always_comb char_count_d = rx_valid_d ? char_count_q + 16'd1 : char_count_q;
  always_ff @(posedge pclk) begin
    if (areset) char_count_q <= '0;
    else char_count_q <= char_count_d;
  end
  assign charCount = char_count_q;
`endif
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: directed SPI master stimulus with hand-computed expectations
module tb_spi_slave_responder;
  logic pclk = 0, areset = 1, cpol = 0, cpha = 0, msbFirst = 1;
  logic sclk = 0, cs = 1, mosi0 = 0, txValid = 0;
  logic [7:0] txData = 0;
  logic miso0, misoOe, txReady, rxValid, txUnderrun, busy;
  logic [7:0] rxData;
`ifdef SPI_SLAVE_CHAR_COUNT_EN
  logic [15:0] charCount;
`endif
  int vectors = 0, errors = 0, rx_cnt = 0, under_cnt = 0, base;
  logic [7:0] got, got2;
  spi_slave_responder dut (
    .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .msbFirst(msbFirst),
    .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0), .misoOe(misoOe),
    .txData(txData), .txValid(txValid), .txReady(txReady), .rxData(rxData),
    .rxValid(rxValid), .txUnderrun(txUnderrun), .busy(busy)
`ifdef SPI_SLAVE_CHAR_COUNT_EN
    , .charCount(charCount)
`endif
  );
  always #5 pclk = ~pclk;
  always @(negedge pclk) begin
    if (rxValid) rx_cnt++;
    if (txUnderrun) under_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic half();
    repeat (5) @(negedge pclk);
  endtask
  task automatic push(input logic [7:0] d);
    @(negedge pclk);
    txValid = 1;
    txData = d;
    @(negedge pclk);
    txValid = 0;
  endtask
  task automatic cs_low();
    sclk = cpol;
    half();
    cs = 0;
    half();
    half();
  endtask
  task automatic cs_high();
    half();
    cs = 1;
    half();
    half();
  endtask
  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    int b;
    rx = 0;
    for (int i = 0; i < nbits; i++) begin
      b = msbFirst ? 7 - i : i;
      if (!cpha) begin
        mosi0 = tx[b];
        half();
        sclk = ~cpol;
        rx[b] = miso0;
        half();
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi0 = tx[b];
        half();
        sclk = cpol;
        rx[b] = miso0;
        half();
      end
    end
    if (!cpha) half();
  endtask
  task automatic reset_pulse();
    @(negedge pclk);
    areset = 1;
    @(negedge pclk);
  endtask
  task automatic chk_reset_state();
    chk("rst_txReady", txReady, 1);
    chk("rst_rxData", rxData, 0);
    chk("rst_rxValid", rxValid, 0);
    chk("rst_txUnderrun", txUnderrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso0", miso0, 0);
    chk("rst_misoOe", misoOe, 0);
  endtask
  initial begin
    repeat (3) @(negedge pclk);
    chk_reset_state();
`ifdef SPI_SLAVE_CHAR_COUNT_EN
    chk("rst_charCount", charCount, 0);
`endif
    areset = 0;
    repeat (3) @(negedge pclk);
    // mode 0, MSB first
    push(8'hA5);
    chk("m0_txReady_full", txReady, 0);
    base = rx_cnt;
    cs_low();
    chk("m0_busy", busy, 1);
    chk("m0_misoOe", misoOe, 1);
    chk("m0_first_bit", miso0, 1);
    chk("m0_txReady_loaded", txReady, 1);
    xfer(8'h3C, 8, got);
    chk("m0_miso_byte", got, 8'hA5);
    chk("m0_rxData", rxData, 8'h3C);
    chk("m0_rx_pulses", rx_cnt - base, 1);
    cs_high();
    chk("m0_idle_busy", busy, 0);
    chk("m0_idle_misoOe", misoOe, 0);
    chk("m0_idle_miso0", miso0, 0);
    // mode 3, LSB first, back-to-back characters
    cpol = 1; cpha = 1; msbFirst = 0;
    push(8'h55);
    base = rx_cnt;
    cs_low();
    push(8'hAA);
    xfer(8'h01, 8, got);
    chk("m3_rxData_1", rxData, 8'h01);
    xfer(8'h80, 8, got2);
    chk("m3_miso_1", got, 8'h55);
    chk("m3_miso_2", got2, 8'hAA);
    chk("m3_rxData_2", rxData, 8'h80);
    chk("m3_rx_pulses", rx_cnt - base, 2);
    cs_high();
    // underrun at cs fall
    cpol = 0; cpha = 0; msbFirst = 1;
    chk("ur_txReady_pre", txReady, 1);
    base = under_cnt;
    cs_low();
    chk("ur_pulse", under_cnt - base, 1);
    xfer(8'h00, 8, got);
    chk("ur_miso_ones", got, 8'hFF);
    chk("ur_txReady_post", txReady, 1);
    cs_high();
    // cs raised mid-character
    base = rx_cnt;
    cs_low();
    push(8'h3A);
    xfer(8'hFF, 5, got);
    cs_high();
    chk("abort_no_rxValid", rx_cnt - base, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hold_kept", txReady, 0);
    cs_low();
    xfer(8'h96, 8, got);
    chk("abort_next_miso", got, 8'h3A);
    chk("abort_next_rxData", rxData, 8'h96);
    chk("abort_next_pulses", rx_cnt - base, 1);
    cs_high();
    // reset at bit 3
    push(8'hE7);
    cs_low();
    xfer(8'h0F, 3, got);
    reset_pulse();
    chk_reset_state();
`ifdef SPI_SLAVE_CHAR_COUNT_EN
    chk("midrst_charCount", charCount, 0);
`endif
    areset = 0;
    base = rx_cnt;
    xfer(8'hFF, 5, got);
    chk("postrst_busy", busy, 0);
    chk("postrst_misoOe", misoOe, 0);
    chk("postrst_no_rxValid", rx_cnt - base, 0);
    cs_high();
    push(8'hC3);
    cs_low();
    xfer(8'h5A, 8, got);
    chk("postrst_miso", got, 8'hC3);
    chk("postrst_rxData", rxData, 8'h5A);
    cs_high();
    // two more characters in one frame
    push(8'h0F);
    cs_low();
    push(8'hF0);
    xfer(8'h12, 8, got);
    xfer(8'h34, 8, got2);
    cs_high();
    chk("pair_miso_1", got, 8'h0F);
    chk("pair_miso_2", got2, 8'hF0);
    chk("pair_rxData", rxData, 8'h34);
`ifdef SPI_SLAVE_CHAR_COUNT_EN
    chk("cc_three", charCount, 3);
    reset_pulse();
    chk("cc_reset", charCount, 0);
    areset = 0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
